// File: rtl/yacc_pkg.sv
// -----------------------------------------------------------------------------
// yacc_pkg
// Shared definitions for the YACC next-level memory responder:
//   - block address field widths {tag, index, subblock, byte offset}
//   - block geometry (64-byte block, 16 x 32-bit beats)
//   - responder FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package yacc_pkg;

    localparam int TAG_W       = 21;
    localparam int IDX_W       = 3;
    localparam int SUB_W       = 2;
    localparam int OFF_W       = 6;
    localparam int ADDR_W      = TAG_W + IDX_W + SUB_W + OFF_W;
    localparam int DATA_W      = 32;
    localparam int BEAT_W      = 4;
    localparam int BLOCK_BYTES = 64;

    // Mask selecting the byte-offset field of a block address.
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_BYTES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_RDATA = 3'd2;
    localparam logic [2:0] ST_WDATA = 3'd3;
    localparam logic [2:0] ST_WACK  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        WAIT  = ST_WAIT,
        RDATA = ST_RDATA,
        WDATA = ST_WDATA,
        WACK  = ST_WACK
    } state_t;

endpackage

// File: rtl/yacc_mem_responder_if.sv
// -----------------------------------------------------------------------------
// yacc_mem_responder_if
// Cache <-> memory responder bus: request channel, writeback data channel and
// read response channel.
//   master : cache side   (drives req_*, wr_valid/wr_data, rsp_ready)
//   slave  : responder    (drives req_ready, wr_ready, rsp_valid/data/last)
// -----------------------------------------------------------------------------
interface yacc_mem_responder_if;
    import yacc_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [ADDR_W-1:0]   req_addr;
    logic                wr_valid;
    logic                wr_ready;
    logic [DATA_W-1:0]   wr_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_last;

    modport master (
        output req_valid, req_write, req_addr, wr_valid, wr_data, rsp_ready,
        input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_write, req_addr, wr_valid, wr_data, rsp_ready,
        output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last
    );

endinterface

// File: rtl/yacc_beat_gen.sv
// -----------------------------------------------------------------------------
// yacc_beat_gen
// Combinational read-data pattern: the byte address of the word being
// returned (block address with offset replaced by beat*4), XORed with SEED.
// Ports:
//   blk_addr in  32  block address (offset bits are ignored)
//   beat     in  4   beat index within the block
//   data     out 32  generated read word
// -----------------------------------------------------------------------------
module yacc_beat_gen
    import yacc_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED = 32'hA5A5_0000
) (
    input  logic [ADDR_W-1:0] blk_addr,
    input  logic [BEAT_W-1:0] beat,
    output logic [DATA_W-1:0] data
);

    logic [ADDR_W-1:0] word_addr;

    assign word_addr = (blk_addr & ~OFF_MASK)
                     | {{(ADDR_W-BEAT_W-2){1'b0}}, beat, 2'b00};
    assign data      = word_addr ^ SEED;

endmodule

// File: rtl/yacc_mem_responder.sv
// -----------------------------------------------------------------------------
// yacc_mem_responder
// Backing-store model for the YACC compressed cache. Answers one request at a
// time: fills return BEATS generated words after LATENCY cycles, writebacks
// absorb BEATS words, fold them into a running XOR checksum and acknowledge.
// Ports:
//   clock    in   1    rising-edge clock
//   resetn   in   1    synchronous reset, active low
//   bus      slave     request / writeback data / read response channels
//   wb_ack   out  1    one-cycle pulse when a writeback completes
//   wb_count out  16   completed writebacks (wraps)
//   wb_csum  out  32   running XOR of all accepted writeback words
// -----------------------------------------------------------------------------
module yacc_mem_responder
    import yacc_pkg::*;
#(
    parameter int                LATENCY = 4,
    parameter int                BEATS   = 16,
    parameter logic [DATA_W-1:0] SEED    = 32'hA5A5_0000
) (
    input  logic                 clock,
    input  logic                 resetn,
    yacc_mem_responder_if.slave  bus,
    output logic                 wb_ack,
    output logic [15:0]          wb_count,
    output logic [DATA_W-1:0]    wb_csum
);

    localparam int                LAT_W     = 16;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [BEAT_W-1:0]  beat;
    logic [ADDR_W-1:0]  blk_addr;
    logic               accept;

    assign accept = (state == IDLE) && bus.req_valid;

    // Control state: FSM, counters and writeback statistics.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            beat     <= '0;
            wb_count <= '0;
            wb_csum  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        beat    <= '0;
                        lat_cnt <= LAT_W'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
                end
                RDATA: begin
                    if (bus.rsp_ready) beat <= beat + 1'b1;
                end
                WDATA: begin
                    if (bus.wr_valid) begin
                        beat    <= beat + 1'b1;
                        wb_csum <= wb_csum ^ bus.wr_data;
                    end
                end
                WACK: begin
                    wb_count <= wb_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Block address is pure data: captured on accept, offset cleared, and
    // only meaningful while a request is in flight, so it needs no reset.
    always_ff @(posedge clock) begin
        if (accept) blk_addr <= bus.req_addr & ~OFF_MASK;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_last  = 1'b0;
        wb_ack        = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = bus.req_write ? WDATA : WAIT;
            end
            WAIT: begin
                if (lat_cnt == '0) state_nxt = RDATA;
            end
            RDATA: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_last  = (beat == LAST_BEAT);
                if (bus.rsp_ready && (beat == LAST_BEAT)) state_nxt = IDLE;
            end
            WDATA: begin
                bus.wr_ready = 1'b1;
                if (bus.wr_valid && (beat == LAST_BEAT)) state_nxt = WACK;
            end
            WACK: begin
                wb_ack    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    yacc_beat_gen #(
        .SEED (SEED)
    ) u_beat_gen (
        .blk_addr (blk_addr),
        .beat     (beat),
        .data     (bus.rsp_data)
    );

endmodule

// File: tb/tb_yacc_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_yacc_mem_responder
// Directed bench for yacc_mem_responder (LATENCY=4, BEATS=16,
// SEED=32'hA5A5_0000). Inputs change 1 time unit after the rising edge and
// outputs are observed in the same window.
// -----------------------------------------------------------------------------
module tb_yacc_mem_responder;

    logic        clock = 1'b0;
    logic        resetn;
    logic        wb_ack;
    logic [15:0] wb_count;
    logic [31:0] wb_csum;

    int checks   = 0;
    int failures = 0;

    yacc_mem_responder_if bus();

    yacc_mem_responder #(
        .LATENCY (4),
        .BEATS   (16),
        .SEED    (32'hA5A5_0000)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bus      (bus),
        .wb_ack   (wb_ack),
        .wb_count (wb_count),
        .wb_csum  (wb_csum)
    );

    always #5 clock = ~clock;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Word byte address of the beat, XOR the seed.
    function automatic logic [31:0] exp_data(input logic [31:0] a, input logic [3:0] b);
        return {a[31:6], b, 2'b00} ^ 32'hA5A5_0000;
    endfunction

    // Issue a fill and consume the whole block; rsp_ready alternates 1/0 when
    // toggle is set. Returns the first and last accepted words.
    task automatic do_fill(input logic [31:0] a, input bit toggle,
                           output logic [31:0] first_d, output logic [31:0] last_d);
        int nb;
        int cyc;
        int lasts;
        first_d = '0;
        last_d  = '0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        check1("fill_req_ready", bus.req_ready, 1'b1);
        tick;
        bus.req_valid = 1'b0;
        check1("fill_busy_req_ready", bus.req_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check1("fill_latency_gap", bus.rsp_valid, 1'b0);
            tick;
        end
        nb    = 0;
        cyc   = 0;
        lasts = 0;
        while (nb < 16 && cyc < 200) begin
            bus.rsp_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            check1 ("fill_rsp_valid", bus.rsp_valid, 1'b1);
            check32("fill_rsp_data", bus.rsp_data, exp_data(a, 4'(nb)));
            check1 ("fill_rsp_last", bus.rsp_last, (nb == 15));
            check1 ("fill_wr_ready", bus.wr_ready, 1'b0);
            if (bus.rsp_ready) begin
                if (nb == 0)  first_d = bus.rsp_data;
                if (nb == 15) last_d  = bus.rsp_data;
                if (bus.rsp_last) lasts++;
                nb++;
            end
            tick;
            cyc++;
        end
        bus.rsp_ready = 1'b0;
        check32("fill_beats", nb, 16);
        check32("fill_cycles", cyc, toggle ? 31 : 16);
        check32("fill_last_count", lasts, 1);
        check1 ("fill_after_req_ready", bus.req_ready, 1'b1);
        check1 ("fill_after_rsp_valid", bus.rsp_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] f0, f15;
        int          cyc;
        int          nb;

        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rsp_ready = 1'b0;
        tick;
        tick;
        check1 ("rst_req_ready", bus.req_ready, 1'b1);
        check1 ("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check1 ("rst_rsp_last", bus.rsp_last, 1'b0);
        check1 ("rst_wr_ready", bus.wr_ready, 1'b0);
        check1 ("rst_wb_ack", wb_ack, 1'b0);
        check32("rst_wb_count", 32'(wb_count), 32'd0);
        check32("rst_wb_csum", wb_csum, 32'd0);
        resetn = 1'b1;
        tick;

        // Plain fill at 0x40.
        do_fill(32'h0000_0040, 1'b0, f0, f15);
        check32("fill_beat0", f0, 32'hA5A5_0040);
        check32("fill_beat15", f15, 32'hA5A5_007C);

        // Same fill with back-pressure every other cycle.
        do_fill(32'h0000_0040, 1'b1, f0, f15);
        check32("stall_beat0", f0, 32'hA5A5_0040);
        check32("stall_beat15", f15, 32'hA5A5_007C);

        // Writeback of words 1..16 at 0x900.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h0000_0900;
        check1("wb_req_ready", bus.req_ready, 1'b1);
        tick;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        for (int d = 1; d <= 16; d++) begin
            check1("wb_wr_ready", bus.wr_ready, 1'b1);
            check1("wb_no_early_ack", wb_ack, 1'b0);
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'(d);
            tick;
            if (d == 8) begin
                // One idle beat mid-burst must not be absorbed.
                bus.wr_valid = 1'b0;
                bus.wr_data  = 32'hFFFF_FFFF;
                tick;
            end
        end
        bus.wr_valid = 1'b0;
        check1("wb_ack_pulse", wb_ack, 1'b1);
        check1("wb_ack_wr_ready", bus.wr_ready, 1'b0);
        tick;
        check1 ("wb_ack_clear", wb_ack, 1'b0);
        check32("wb_count_one", 32'(wb_count), 32'd1);
        check32("wb_csum_val", wb_csum, 32'h0000_0010);
        check1 ("wb_idle_req_ready", bus.req_ready, 1'b1);

        // Stray writeback beats in IDLE and during a fill.
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hDEAD_BEEF;
        tick;
        tick;
        check1 ("stray_idle_req_ready", bus.req_ready, 1'b1);
        check32("stray_idle_csum", wb_csum, 32'h0000_0010);
        check32("stray_idle_count", 32'(wb_count), 32'd1);
        do_fill(32'h0000_0040, 1'b0, f0, f15);
        bus.wr_valid = 1'b0;
        check32("stray_fill_csum", wb_csum, 32'h0000_0010);
        check32("stray_fill_count", 32'(wb_count), 32'd1);
        check1 ("stray_fill_ack", wb_ack, 1'b0);

        // req_valid held high through a fill; second request at 0x1140.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0040;
        tick;
        bus.req_addr  = 32'h0000_1140;
        bus.rsp_ready = 1'b1;
        cyc = 0;
        nb  = 0;
        while (nb < 16 && cyc < 100) begin
            check1("hold_req_ready_busy", bus.req_ready, 1'b0);
            if (bus.rsp_valid) begin
                check32("hold_first_data", bus.rsp_data, exp_data(32'h0000_0040, 4'(nb)));
                nb++;
            end
            tick;
            cyc++;
        end
        check32("hold_first_beats", nb, 16);
        check1 ("hold_req_ready_after_last", bus.req_ready, 1'b1);
        tick;
        bus.req_valid = 1'b0;
        check1("hold_second_accepted", bus.req_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check1("hold_second_gap", bus.rsp_valid, 1'b0);
            tick;
        end
        check1 ("hold_second_valid", bus.rsp_valid, 1'b1);
        check32("hold_second_beat0", bus.rsp_data, 32'hA5A5_1140);
        cyc = 0;
        while (!(bus.rsp_valid && bus.rsp_last) && cyc < 40) begin
            tick;
            cyc++;
        end
        check1("hold_second_last", bus.rsp_last, 1'b1);
        tick;
        bus.rsp_ready = 1'b0;
        check1("hold_second_done", bus.req_ready, 1'b1);

        // Reset in the middle of a fill at beat 7.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0080;
        tick;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        cyc = 0;
        while (!(bus.rsp_valid && bus.rsp_data == exp_data(32'h0000_0080, 4'd7)) && cyc < 40) begin
            tick;
            cyc++;
        end
        check32("mid_beat7_data", bus.rsp_data, 32'hA5A5_009C);
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        check1 ("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        check1 ("mid_rst_req_ready", bus.req_ready, 1'b1);
        check32("mid_rst_wb_count", 32'(wb_count), 32'd0);
        check32("mid_rst_wb_csum", wb_csum, 32'd0);
        tick;
        check1("mid_rst_no_resume", bus.rsp_valid, 1'b0);
        bus.rsp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
